// File: rtl/stepper_phase_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : stepper_phase_monitor_if
// Description : Coil-pattern observation bus for the stepper phase monitor.
// Revision    : 1.0  initial release
// ============================================================================
interface stepper_phase_monitor_if #(
    parameter int POS_W = 16
);
    logic [3:0]       q_in;
    logic             clr;
    logic             step_pulse;
    logic             dir;
    logic [POS_W-1:0] position;
    logic             move_valid;
    logic [7:0]       move_word;
    logic             fault;

    // master drives the coil pattern and clear; slave is the monitor itself
    modport master (
        output q_in,
        output clr,
        input  step_pulse,
        input  dir,
        input  position,
        input  move_valid,
        input  move_word,
        input  fault
    );

    modport slave (
        input  q_in,
        input  clr,
        output step_pulse,
        output dir,
        output position,
        output move_valid,
        output move_word,
        output fault
    );
endinterface
`default_nettype wire

// File: rtl/stepper_phase_monitor.sv
`default_nettype none
// ============================================================================
// Module      : stepper_phase_monitor
// Description : Decodes one-hot coil transitions into steps, tracks position,
//               groups steps into moves and flags illegal patterns.
// Revision    : 1.0  initial release
// ============================================================================
module stepper_phase_monitor #(
    parameter int POS_W       = 16,
    parameter int IDLE_CYCLES = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    stepper_phase_monitor_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_MOVING = 1'b1
    } state_t;

    localparam logic [7:0]       c_idle_cycles = 8'(IDLE_CYCLES);
    localparam logic [6:0]       c_count_max   = 7'd127;
    localparam logic [POS_W-1:0] c_pos_one     = {{(POS_W-1){1'b0}}, 1'b1};

    function automatic logic f_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    function automatic logic f_multi(input logic [3:0] v);
        return (v & (v - 4'd1)) != 4'b0000;
    endfunction

    logic [3:0]       r_q_prev;
    logic             r_step_pulse;
    logic             r_dir;
    logic [POS_W-1:0] r_position;
    logic             r_move_valid;
    logic [7:0]       r_move_word;
    logic             r_fault;
    state_t           r_state;
    logic [6:0]       r_count;
    logic [7:0]       r_timer;
    logic             r_mdir;

    logic             w_prev_onehot;
    logic             w_in_onehot;
    logic             w_fwd;
    logic             w_rev;
    logic             w_step;
    logic             w_fault_ev;

    state_t           w_state_nxt;
    logic [6:0]       w_count_nxt;
    logic [7:0]       w_timer_nxt;
    logic             w_mdir_nxt;
    logic             w_emit;
    logic [7:0]       w_emit_word;

    // ------------------------------------------------------------------
    // Transition decode: every comparison is against the previous pattern
    // ------------------------------------------------------------------
    assign w_prev_onehot = f_onehot(r_q_prev);
    assign w_in_onehot   = f_onehot(bus.q_in);
    assign w_fwd         = w_prev_onehot && (bus.q_in == {r_q_prev[2:0], r_q_prev[3]});
    assign w_rev         = w_prev_onehot && (bus.q_in == {r_q_prev[0], r_q_prev[3:1]});
    assign w_step        = w_fwd || w_rev;

    // Only a two-position jump is left once rotations and holds are excluded
    assign w_fault_ev    = f_multi(bus.q_in) ||
                           (w_prev_onehot && w_in_onehot &&
                            (bus.q_in != r_q_prev) && !w_step);

    // ------------------------------------------------------------------
    // Move FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= 7'd0;
            r_timer <= 8'd0;
            r_mdir  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_timer <= w_timer_nxt;
            r_mdir  <= w_mdir_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Move FSM: next state and emit decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_timer_nxt = r_timer;
        w_mdir_nxt  = r_mdir;
        w_emit      = 1'b0;
        w_emit_word = {r_mdir, r_count};

        if (bus.clr) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = 7'd0;
            w_timer_nxt = 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_step) begin
                        w_state_nxt = ST_MOVING;
                        w_count_nxt = 7'd1;
                        w_mdir_nxt  = w_rev;
                        w_timer_nxt = 8'd0;
                    end
                end
                ST_MOVING: begin
                    if (w_step && (w_rev == r_mdir)) begin
                        w_timer_nxt = 8'd0;
                        // A full 7-bit move closes on its 127th step
                        if (r_count == (c_count_max - 7'd1)) begin
                            w_emit      = 1'b1;
                            w_emit_word = {r_mdir, c_count_max};
                            w_state_nxt = ST_IDLE;
                            w_count_nxt = 7'd0;
                        end else begin
                            w_count_nxt = r_count + 7'd1;
                        end
                    end else if (w_step) begin
                        w_emit      = 1'b1;
                        w_emit_word = {r_mdir, r_count};
                        w_count_nxt = 7'd1;
                        w_mdir_nxt  = w_rev;
                        w_timer_nxt = 8'd0;
                    end else if ((r_timer + 8'd1) == c_idle_cycles) begin
                        w_emit      = 1'b1;
                        w_emit_word = {r_mdir, r_count};
                        w_state_nxt = ST_IDLE;
                        w_count_nxt = 7'd0;
                        w_timer_nxt = 8'd0;
                    end else begin
                        w_timer_nxt = r_timer + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = 7'd0;
                    w_timer_nxt = 8'd0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Step, position, fault and move-report registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_prev     <= 4'b0000;
            r_step_pulse <= 1'b0;
            r_dir        <= 1'b0;
            r_position   <= '0;
            r_move_valid <= 1'b0;
            r_move_word  <= 8'h00;
            r_fault      <= 1'b0;
        end else begin
            r_q_prev <= bus.q_in;
            if (bus.clr) begin
                r_step_pulse <= 1'b0;
                r_position   <= '0;
                r_move_valid <= 1'b0;
                r_fault      <= 1'b0;
            end else begin
                r_step_pulse <= w_step;
                r_move_valid <= w_emit;
                if (w_fault_ev) begin
                    r_fault <= 1'b1;
                end
                if (w_step) begin
                    r_dir <= w_rev;
                    if (w_rev) begin
                        r_position <= r_position - c_pos_one;
                    end else begin
                        r_position <= r_position + c_pos_one;
                    end
                end
                if (w_emit) begin
                    r_move_word <= w_emit_word;
                end
            end
        end
    end

    assign bus.step_pulse = r_step_pulse;
    assign bus.dir        = r_dir;
    assign bus.position   = r_position;
    assign bus.move_valid = r_move_valid;
    assign bus.move_word  = r_move_word;
    assign bus.fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_stepper_phase_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_stepper_phase_monitor
// Description : Directed self-checking bench for stepper_phase_monitor.
// Revision    : 1.0  initial release
// ============================================================================
module tb_stepper_phase_monitor;

    localparam int POS_W       = 8;
    localparam int IDLE_CYCLES = 8;

    logic clk;
    logic rst_n;

    stepper_phase_monitor_if #(.POS_W(POS_W)) bus ();

    stepper_phase_monitor #(
        .POS_W       (POS_W),
        .IDLE_CYCLES (IDLE_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int cyc           = 0;
    int steps         = 0;
    int emits         = 0;
    int last_step_cyc = 0;
    int emit_cyc      = 0;
    logic [7:0] ew [0:7];
    int         es [0:7];

    task automatic clear_stats();
        steps         = 0;
        emits         = 0;
        last_step_cyc = 0;
        emit_cyc      = 0;
        for (int i = 0; i < 8; i++) begin
            ew[i] = 8'h00;
            es[i] = 0;
        end
    endtask

    // Advance one clock and sample just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.step_pulse === 1'b1) begin
            steps++;
            last_step_cyc = cyc;
        end
        if (bus.move_valid === 1'b1) begin
            if (emits < 8) begin
                ew[emits] = bus.move_word;
                es[emits] = steps;
            end
            emits++;
            emit_cyc = cyc;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] q;

        // ---------------- reset state ----------------
        rst_n      = 1'b0;
        bus.q_in   = 4'b0000;
        bus.clr    = 1'b0;
        clear_stats();
        ticks(3);
        check("rst_position",   32'(bus.position),   32'h0);
        check("rst_fault",      32'(bus.fault),      32'h0);
        check("rst_step_pulse", 32'(bus.step_pulse), 32'h0);
        check("rst_dir",        32'(bus.dir),        32'h0);
        check("rst_move_valid", 32'(bus.move_valid), 32'h0);
        check("rst_move_word",  32'(bus.move_word),  32'h0);
        rst_n = 1'b1;

        // ---------------- forward run with gaps ----------------
        clear_stats();
        bus.q_in = 4'b0000; ticks(2);
        bus.q_in = 4'b0001; ticks(2);
        bus.q_in = 4'b0010; ticks(2);
        bus.q_in = 4'b0100; ticks(2);
        bus.q_in = 4'b1000; ticks(2);
        bus.q_in = 4'b0001; ticks(2);
        ticks(20);
        check("fwd_steps",     32'(steps),         32'd4);
        check("fwd_dir",       32'(bus.dir),       32'h0);
        check("fwd_position",  32'(bus.position),  32'h04);
        check("fwd_emits",     32'(emits),         32'd1);
        check("fwd_word",      32'(ew[0]),         32'h04);
        check("fwd_emit_lag",  32'(emit_cyc - last_step_cyc), 32'(IDLE_CYCLES));
        check("fwd_fault",     32'(bus.fault),     32'h0);

        // ---------------- reversal ----------------
        clear_stats();
        bus.q_in = 4'b1000; ticks(2);
        bus.q_in = 4'b0100; ticks(2);
        bus.q_in = 4'b1000; ticks(2);
        bus.q_in = 4'b0001; ticks(2);
        ticks(20);
        check("rev_steps",    32'(steps),        32'd4);
        check("rev_emits",    32'(emits),        32'd2);
        check("rev_word0",    32'(ew[0]),        32'h82);
        check("rev_word1",    32'(ew[1]),        32'h02);
        check("rev_position", 32'(bus.position), 32'h04);
        check("rev_dir",      32'(bus.dir),      32'h0);

        // ---------------- wrap and 127-step cap ----------------
        bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        check("wrap_clr_position", 32'(bus.position), 32'h0);
        clear_stats();
        q = 4'b0001;
        for (int i = 0; i < 130; i++) begin
            q = {q[0], q[3:1]};
            bus.q_in = q;
            tick();
        end
        ticks(20);
        check("wrap_steps",    32'(steps),        32'd130);
        check("wrap_position", 32'(bus.position), 32'h7E);
        check("wrap_emits",    32'(emits),        32'd2);
        check("wrap_word0",    32'(ew[0]),        32'hFF);
        check("wrap_word0_at", 32'(es[0]),        32'd127);
        check("wrap_word1",    32'(ew[1]),        32'h83);
        check("wrap_dir",      32'(bus.dir),      32'h1);

        // ---------------- illegal patterns ----------------
        bus.q_in = 4'b0000; tick();
        bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        bus.q_in = 4'b0001; tick();
        bus.q_in = 4'b0010; tick();
        check("ill_pre_step",     32'(bus.step_pulse), 32'h1);
        check("ill_pre_position", 32'(bus.position),   32'h01);
        clear_stats();
        bus.q_in = 4'b1000; tick();
        check("ill_jump_fault",    32'(bus.fault),      32'h1);
        check("ill_jump_step",     32'(bus.step_pulse), 32'h0);
        check("ill_jump_position", 32'(bus.position),   32'h01);
        bus.q_in = 4'b0101; tick();
        check("ill_multi_fault",    32'(bus.fault),    32'h1);
        check("ill_multi_position", 32'(bus.position), 32'h01);
        bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        check("ill_clr_fault",    32'(bus.fault),    32'h0);
        check("ill_clr_position", 32'(bus.position), 32'h0);
        bus.q_in = 4'b0000; ticks(12);
        check("ill_dropped_move", 32'(emits),     32'd0);
        check("ill_steps",        32'(steps),     32'd0);
        check("ill_fault_after",  32'(bus.fault), 32'h0);

        // ---------------- energise / de-energise ----------------
        clear_stats();
        bus.q_in = 4'b0010; ticks(2);
        bus.q_in = 4'b0000; ticks(2);
        bus.q_in = 4'b1000; ticks(2);
        check("ene_steps",    32'(steps),        32'd0);
        check("ene_fault",    32'(bus.fault),    32'h0);
        check("ene_position", 32'(bus.position), 32'h0);

        // ---------------- clr collision ----------------
        bus.q_in = 4'b0000; tick();
        bus.q_in = 4'b0001; tick();
        clear_stats();
        bus.q_in = 4'b0010; bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        check("col_step",     32'(bus.step_pulse), 32'h0);
        check("col_position", 32'(bus.position),   32'h0);
        bus.q_in = 4'b0100; tick();
        check("col_next_step",     32'(bus.step_pulse), 32'h1);
        check("col_next_position", 32'(bus.position),   32'h01);
        bus.q_in = 4'b1000; tick();
        check("col_mid_position",  32'(bus.position),   32'h02);

        // ---------------- asynchronous reset mid-move ----------------
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_position",   32'(bus.position),   32'h0);
        check("arst_step_pulse", 32'(bus.step_pulse), 32'h0);
        check("arst_dir",        32'(bus.dir),        32'h0);
        check("arst_move_valid", 32'(bus.move_valid), 32'h0);
        check("arst_move_word",  32'(bus.move_word),  32'h0);
        check("arst_fault",      32'(bus.fault),      32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_stats();
        ticks(12);
        check("arst_no_emit",   32'(emits),        32'd0);
        check("arst_no_steps",  32'(steps),        32'd0);
        check("arst_position2", 32'(bus.position), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stepper_phase_monitor.md
Name: stepper_phase_monitor

Overview:
- Observes the 4-bit one-hot coil pattern that the stepper driver produces.
- Decodes each legal phase transition into a step and its direction, and keeps a signed absolute position.
- Groups consecutive same-direction steps into moves and reports each finished move as an 8-bit word in the driver's command format {dir, count[6:0]}.
- Flags illegal coil patterns and illegal transitions. Used for closed-loop verification and position tracking.

Parameters:
- POS_W, 16, width of the signed position counter (two's complement).
- IDLE_CYCLES, 8, number of clk cycles without a step that ends a move. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- q_in  input  4  coil pattern; synchronous to clk.
- clr  input  1  synchronous clear of position, fault and move state.
- step_pulse  output  1  one-cycle pulse per decoded step.
- dir  output  1  direction of the last decoded step; 0 = forward, 1 = reverse.
- position  output  POS_W  signed step position.
- move_valid  output  1  one-cycle pulse; move_word is valid.
- move_word  output  8  {dir, count[6:0]} of the completed move.
- fault  output  1  sticky illegal-pattern or illegal-transition flag.

Behaviour:
- Reset (rst_n low, asynchronous) clears: q_prev=4'b0000, step_pulse=0, dir=0, position=0, move_valid=0, move_word=8'h00, fault=0, state=IDLE, count=0, idle timer=0.
- Capture: q_prev <= q_in every cycle, including cycles with clr asserted. All decode compares q_in against q_prev.
- Forward step: q_prev one-hot and q_in == rotate-left(q_prev). Sequence is 0001 -> 0010 -> 0100 -> 1000 -> 0001.
- Reverse step: q_prev one-hot and q_in == rotate-right(q_prev).
- No step, no fault: q_in == q_prev; 0000 -> any one-hot (energise); one-hot -> 0000 (de-energise).
- Fault: q_in has two or more bits set, or a one-hot to one-hot jump by two positions (for example 0001 -> 0100). On fault: fault <= 1 (sticky until clr or reset); no step is counted; position is unchanged.
- Latency: step_pulse, dir and position update on the clk edge that samples the new q_in, so they are visible one cycle after q_in changes.
- Position arithmetic: +1 forward, -1 reverse, wraps modulo 2^POS_W. No saturation.
- Move FSM:
  - IDLE: on a step -> MOVING, with count=1, move direction = step direction, timer=0.
  - MOVING, same-direction step: count+1, timer=0.
  - MOVING, no step: timer+1. When the timer reaches IDLE_CYCLES, emit the move and go to IDLE.
  - MOVING, opposite-direction step: emit the old move that cycle; stay in MOVING with count=1 and the new direction.
  - MOVING, count reaches 127: emit {dir,127} on the 127th step and go to IDLE. The next step starts a fresh move. count never exceeds 127 and the 7-bit field never wraps.
- Emit: move_valid=1 for exactly one cycle; move_word holds its value until the next emit.
- Simultaneous timeout and opposite step: the opposite step resets the timer, so a single emit occurs (old move). This is the reversal rule.
- Faults do not end a move and do not reset the timer.
- clr: synchronous and highest priority. Clears position, fault, count, timer, step_pulse and move_valid, and forces IDLE. A step in the same cycle is discarded and not counted, but q_prev still updates. An in-progress move is dropped without emit. move_word and dir are not cleared.
- Reset mid-move: the partial move is lost and no emit occurs.

Test Plan:
- Forward run with gaps: after reset, drive 0000, then 0001, 0010, 0100, 1000, 0001, holding each 2 cycles, then hold 20 cycles. Required: 4 step_pulses; dir=0; position=4; one move_valid with move_word=8'h04, exactly IDLE_CYCLES cycles after the last step.
- Reversal: from position 4 with phase 0001, drive 1000, 0100, then 1000, 0001. Required: emit 8'h82; then after timeout emit 8'h02; position=4.
- Wrap and saturation: with POS_W=8, perform 130 reverse steps from 0. Required: position=8'h7E (-130 mod 256); emits 8'hFF at the 127th step, then 8'h83 after timeout.
- Illegal patterns: drive 0001 -> 0100. Required: fault=1, no step_pulse, position unchanged. Then 0101 keeps fault=1. clr for 1 cycle gives fault=0 and position=0.
- Energise/de-energise: drive 0000 -> 0010 -> 0000 -> 1000. Required: no steps and no fault.
- clr collision and async reset: assert clr in the cycle 0001 -> 0010 is sampled. Required: no step counted and q_prev=0010, so a following 0100 counts as +1 (position=1). Drop rst_n mid-move between edges. Required: all outputs 0 immediately, with no move_valid.
